// File: rtl/hazard_ctrl_unit.sv
// Pipeline hazard controller: load-use RAW detection, EX redirect flush,
// multi-cycle MDU occupancy tracking and a saturating stall-cycle counter.
module hazard_ctrl_unit #(
    parameter int REG_ADDR_W  = 5,
    parameter int MDU_LATENCY = 4,
    parameter int STALL_CNT_W = 16
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   id_valid,
    input  logic [REG_ADDR_W-1:0]  id_rs1,
    input  logic [REG_ADDR_W-1:0]  id_rs2,
    input  logic                   id_uses_rs1,
    input  logic                   id_uses_rs2,
    input  logic                   id_is_mdu,
    input  logic                   id_reads_mdu,
    input  logic                   ex_mem_read,
    input  logic [REG_ADDR_W-1:0]  ex_write_reg,
    input  logic                   ex_branch_taken,
    output logic                   pc_write,
    output logic                   ifid_write,
    output logic                   if_flush,
    output logic                   idex_bubble,
    output logic                   mdu_busy,
    output logic [STALL_CNT_W-1:0] stall_count
);

    localparam int CNT_W = $clog2(MDU_LATENCY + 1);
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MDU_LATENCY);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(1);

    typedef enum logic {
        IDLE,
        MDU_BUSY
    } state_t;

    state_t             state;
    logic [CNT_W-1:0]   mdu_cnt;
    logic               load_use;
    logic               mdu_hz;
    logic               stall;
    logic               issue;
    logic               stall_cycle;

    // Register 0 is hardwired, so a load targeting it can never create a dependency.
    assign load_use = id_valid && ex_mem_read && (ex_write_reg != '0) &&
                      ((id_uses_rs1 && (id_rs1 == ex_write_reg)) ||
                       (id_uses_rs2 && (id_rs2 == ex_write_reg)));
    assign mdu_hz      = id_valid && (id_is_mdu || id_reads_mdu) && (state == MDU_BUSY);
    assign stall       = load_use || mdu_hz;
    assign issue       = id_valid && id_is_mdu && !stall && !ex_branch_taken;
    assign stall_cycle = stall && !ex_branch_taken;
    assign mdu_busy    = (state == MDU_BUSY);

    // The redirect outranks a stall: the ID instruction is wrong-path and gets flushed.
    always_comb begin
        pc_write    = 1'b1;
        ifid_write  = 1'b1;
        if_flush    = 1'b0;
        idex_bubble = 1'b0;
        if (!rst_n) begin
            pc_write    = 1'b0;
            ifid_write  = 1'b0;
            if_flush    = 1'b1;
            idex_bubble = 1'b1;
        end else if (ex_branch_taken) begin
            if_flush    = 1'b1;
            idex_bubble = 1'b1;
        end else if (stall) begin
            pc_write    = 1'b0;
            ifid_write  = 1'b0;
            idex_bubble = 1'b1;
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // pre-edge values, independent of block evaluation order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            mdu_cnt <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (issue) begin
                        state   <= MDU_BUSY;
                        mdu_cnt <= CNT_LOAD;
                    end
                end
                MDU_BUSY: begin
                    if (mdu_cnt == CNT_LAST) begin
                        state   <= IDLE;
                        mdu_cnt <= '0;
                    end else begin
                        mdu_cnt <= mdu_cnt - CNT_LAST;
                    end
                end
                default: begin
                    state   <= IDLE;
                    mdu_cnt <= '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_count <= '0;
        end else if (stall_cycle && (stall_count != '1)) begin
            stall_count <= stall_count + 1'b1;
        end
    end

endmodule

// File: doc/hazard_ctrl_unit.md
Name: hazard_ctrl_unit

Overview:
- Parametrised hazard controller for the 5-stage pipeline. It replaces the opcode-only combinational hazard logic.
- Detects load-use RAW hazards and resolves EX-stage branch/jump redirects.
- Tracks an in-flight multi-cycle multiply/divide (MDU) operation with a countdown FSM.
- Drives PC/IF-ID write enables, IF flush and ID/EX bubble, and keeps a saturating stall-cycle counter for performance monitoring.

Parameters:
- REG_ADDR_W, 5: register-specifier width.
- MDU_LATENCY, 4: cycles an MDU op occupies the unit after issue (≥1).
- STALL_CNT_W, 16: width of the stall performance counter.

Ports:
- clk  in  1  pipeline clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- id_valid  in  1  ID stage holds a real instruction.
- id_rs1  in  REG_ADDR_W  ID source register 1.
- id_rs2  in  REG_ADDR_W  ID source register 2.
- id_uses_rs1  in  1  ID instruction reads rs1.
- id_uses_rs2  in  1  ID instruction reads rs2.
- id_is_mdu  in  1  ID instruction is an MDU op.
- id_reads_mdu  in  1  ID instruction reads the MDU result (HI/LO move).
- ex_mem_read  in  1  EX instruction is a load.
- ex_write_reg  in  REG_ADDR_W  EX destination register.
- ex_branch_taken  in  1  EX resolved a taken branch/jump (pc_src≠0).
- pc_write  out  1  PC update enable.
- ifid_write  out  1  IF/ID register write enable.
- if_flush  out  1  clear IF/ID to NOP.
- idex_bubble  out  1  insert NOP into ID/EX.
- mdu_busy  out  1  MDU op in flight.
- stall_count  out  STALL_CNT_W  saturating count of stall cycles.

Behaviour:
- State: FSM {IDLE, MDU_BUSY}, down-counter mdu_cnt (clog2(MDU_LATENCY+1) bits), stall_count register.
- Async reset (rst_n=0):
  - Registers: state=IDLE, mdu_cnt=0, stall_count=0.
  - Outputs forced while rst_n=0: pc_write=0, ifid_write=0, if_flush=1, idex_bubble=1, mdu_busy=0.
- Hazard terms (combinational from inputs + state):
  - load_use = id_valid & ex_mem_read & ex_write_reg≠0 & ((id_uses_rs1 & id_rs1==ex_write_reg) | (id_uses_rs2 & id_rs2==ex_write_reg)).
  - mdu_hz = id_valid & (id_is_mdu | id_reads_mdu) & state==MDU_BUSY.
  - stall = load_use | mdu_hz.
- Output priority (rst_n=1):
  1. ex_branch_taken=1: if_flush=1, idex_bubble=1, pc_write=1, ifid_write=1. The redirect wins, and any concurrent stall is discarded because the ID instruction is wrong-path.
  2. Else stall=1: pc_write=0, ifid_write=0, idex_bubble=1, if_flush=0.
  3. Else: pc_write=1, ifid_write=1, if_flush=0, idex_bubble=0.
- Outputs are combinational; same-cycle response, zero latency.
- MDU issue = id_valid & id_is_mdu & ~stall & ~ex_branch_taken.
- FSM transitions (posedge clk):
  - IDLE, issue=1 → MDU_BUSY, mdu_cnt=MDU_LATENCY.
  - MDU_BUSY → mdu_cnt decrements each cycle. When mdu_cnt==1 the next state is IDLE and mdu_cnt=0.
  - MDU_BUSY at mdu_cnt==1 with an ID MDU op waiting: that op is still stalled this cycle. It issues on the following cycle from IDLE, so there is no back-to-back chaining.
  - A branch redirect does not cancel an in-flight MDU op (it issued from the correct path).
- mdu_busy = (state==MDU_BUSY).
- stall_count:
  - Increments by 1 on each clk edge where priority-2 stall was asserted.
  - Saturates at all-ones; never wraps.
  - Branch flush cycles are not counted.
- Register 0 is never a hazard source (ex_write_reg==0 ignored).
- id_valid=0 suppresses all stalls but not branch flush.
- Reset mid-MDU: returns to IDLE immediately; the pending count is discarded.

Test Plan:
1. Load-use: ex_mem_read=1, ex_write_reg=8, id_rs1=8, id_uses_rs1=1 → pc_write=0, ifid_write=0, idex_bubble=1 for that cycle; stall_count 0→1.
2. Same as 1 with ex_write_reg=0, or id_uses_rs1=0 → no stall; pc_write=1, idex_bubble=0.
3. MDU issue with MDU_LATENCY=4, then id_reads_mdu=1 held → mdu_busy high exactly 4 cycles, stall asserted 4 cycles, release on 5th; stall_count=4.
4. Load-use and ex_branch_taken=1 in the same cycle → if_flush=1, idex_bubble=1, pc_write=1; stall_count unchanged.
5. id_is_mdu=1 with ex_branch_taken=1 → no issue, mdu_busy stays 0. Also: rst_n pulled low at mdu_cnt=2 → mdu_busy=0 asynchronously, and outputs take their reset values.
6. STALL_CNT_W=4: force 20 stall cycles → stall_count saturates at 15.
